// File: rtl/bcd_sequence_checker_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bcd_sequence_checker_pkg - FSM state type, BCD limits and counter helpers.
// Rev 1.0
// -----------------------------------------------------------------------------
package bcd_sequence_checker_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int MISS_W = 2;
  localparam logic [MISS_W-1:0] MISS_LIMIT = 2'd3;
  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_next_predict.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bcd_next_predict - next value of a 0..9 up/down counter given its last state.
// Rev 1.0
// -----------------------------------------------------------------------------
module bcd_next_predict
  import bcd_sequence_checker_pkg::*;
(
  input  logic [3:0] q_prev,
  input  logic       en,
  input  logic       dir,
  output logic [3:0] expected
);

  always_comb begin
    expected = q_prev;
    if (en) begin
      if (!dir) begin
        // Anything at or above the top digit rolls over to 0 when counting up.
        expected = (q_prev >= BCD_MAX) ? 4'd0 : q_prev + 4'd1;
      end else begin
        expected = (q_prev == 4'd0) ? BCD_MAX : q_prev - 4'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bcd_sequence_checker.sv
`default_nettype none
// -----------------------------------------------------------------------------
// bcd_sequence_checker - watches a BCD counter output and flags illegal steps.
// Rev 1.0
// -----------------------------------------------------------------------------
module bcd_sequence_checker
  import bcd_sequence_checker_pkg::*;
(
  input  logic             clki,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             direction,
  input  logic [3:0]       q,
  output logic             locked,
  output logic             fault,
  output logic             error,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count,
  output logic [3:0]       expected
);

  state_t              r_state;
  logic [3:0]          r_q_prev;
  logic                r_en_prev;
  logic                r_dir_prev;
  logic [MISS_W-1:0]   r_miss;
  logic                r_error;
  logic [CNT_W-1:0]    r_err_count;
  logic [CNT_W-1:0]    r_wrap_count;
  logic [3:0]          r_expected;

  logic [3:0]          w_pred;
  logic                w_q_legal;
  logic                w_mismatch;
  state_t              w_state_nxt;
  logic [MISS_W-1:0]   w_miss_nxt;
  logic                w_err_pulse;
  logic                w_wrap_hit;

  bcd_next_predict u_predict (
    .q_prev   (r_q_prev),
    .en       (r_en_prev),
    .dir      (r_dir_prev),
    .expected (w_pred)
  );

  assign w_q_legal  = (q <= BCD_MAX);
  // An out-of-range digit can never match, even if the model has resynced to it.
  assign w_mismatch = !w_q_legal || (q != w_pred);

  always_comb begin
    w_state_nxt = r_state;
    w_miss_nxt  = r_miss;
    w_err_pulse = 1'b0;
    w_wrap_hit  = 1'b0;
    case (r_state)
      UNLOCKED: begin
        w_miss_nxt = '0;
        if (w_q_legal) begin
          w_state_nxt = LOCKED;
        end
      end
      LOCKED: begin
        if (w_mismatch) begin
          w_err_pulse = 1'b1;
          w_miss_nxt  = r_miss + 1'b1;
          if (r_miss == MISS_LIMIT - 1'b1) begin
            w_state_nxt = FAULT;
          end
        end else begin
          w_miss_nxt = '0;
          w_wrap_hit = (!r_dir_prev && (r_q_prev == BCD_MAX) && (q == 4'd0)) ||
                       ( r_dir_prev && (r_q_prev == 4'd0) && (q == BCD_MAX));
        end
      end
      FAULT: begin
        w_state_nxt = FAULT;
      end
      default: begin
        w_state_nxt = UNLOCKED;
        w_miss_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clki or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= UNLOCKED;
      r_q_prev     <= '0;
      r_en_prev    <= 1'b0;
      r_dir_prev   <= 1'b0;
      r_miss       <= '0;
      r_error      <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_expected   <= '0;
    end else begin
      // History is tracked every cycle so the model always resyncs to what was seen.
      r_q_prev   <= q;
      r_en_prev  <= enable;
      r_dir_prev <= direction;
      if (clear) begin
        r_state      <= UNLOCKED;
        r_miss       <= '0;
        r_error      <= 1'b0;
        r_err_count  <= '0;
        r_wrap_count <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_miss  <= w_miss_nxt;
        r_error <= w_err_pulse;
        if (w_err_pulse) begin
          r_err_count <= sat_inc(r_err_count);
        end
        if (w_wrap_hit) begin
          r_wrap_count <= sat_inc(r_wrap_count);
        end
        if (r_state == LOCKED) begin
          r_expected <= w_pred;
        end
      end
    end
  end

  assign locked     = (r_state == LOCKED);
  assign fault      = (r_state == FAULT);
  assign error      = r_error;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;
  assign expected   = r_expected;

endmodule
`default_nettype wire

// File: doc/bcd_sequence_checker.md
BCD_SEQUENCE_CHECKER -- requirements
Module: bcd_sequence_checker

Interface
REQ-001 The block SHALL have these ports:
- clki  in  1  single clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous clear of FSM and counters; priority over all other sync activity.
- enable  in  1  observed counter enable, same signal that drives the counter under check.
- direction  in  1  observed counter direction: 0 = up (0..9), 1 = down (9..0).
- q  in  4  observed counter output.
- locked  out  1  high while in LOCKED.
- fault  out  1  high while in FAULT; sticky.
- error  out  1  one-cycle pulse per detected mismatch.
- err_count  out  8  mismatches since reset/clear; saturates at 255.
- wrap_count  out  8  correct wrap transitions since reset/clear; saturates at 255.
- expected  out  4  prediction used in the current compare.
REQ-002 The block SHALL be parameterless; no internal clock gating or second clock.

Function
REQ-003 Internal registers SHALL capture q_prev, en_prev and dir_prev every cycle.
REQ-004 The prediction SHALL be:
- en_prev=0: q_prev.
- en_prev=1, dir_prev=0: q_prev+1, with 9 -> 0.
- en_prev=1, dir_prev=1: q_prev-1, with 0 -> 9.
REQ-005 Any q in 10..15 SHALL count as a mismatch in LOCKED and SHALL be ignored in UNLOCKED.
REQ-006 The FSM SHALL have three states: UNLOCKED, LOCKED and FAULT.
REQ-007 UNLOCKED: the first cycle with q<=9 SHALL load q_prev and move to LOCKED the next cycle; no compare in this state.
REQ-008 LOCKED: every cycle q SHALL be compared to the prediction.
- Match: miss counter := 0.
- Mismatch: error pulses for 1 cycle, err_count++, miss counter++, and the model resyncs to the observed q.
REQ-009 Three consecutive mismatches SHALL move LOCKED -> FAULT; the third mismatch also pulses error and increments err_count.
REQ-010 FAULT SHALL hold until clear or reset.
- No compares, no error pulses, no counter updates while in FAULT.
- expected holds its last value.
REQ-011 A matched 9->0 transition with dir_prev=0, or a matched 0->9 transition with dir_prev=1, SHALL increment wrap_count.
REQ-012 A mismatch whose observed value is 9->0 or 0->9 SHALL NOT increment wrap_count.
REQ-013 Both counters SHALL saturate; a mismatch at err_count=255 still pulses error.
REQ-014 clear=1 SHALL zero both counters and the miss counter, deassert error, and enter UNLOCKED on the next edge, in any state.
REQ-015 Compare latency SHALL be 1 cycle: error, err_count and wrap_count update on the edge after the offending q is sampled.

Reset
REQ-016 reset_n low SHALL asynchronously force:
- FSM = UNLOCKED, locked=0, fault=0, error=0.
- err_count=0, wrap_count=0, expected=0.
- q_prev=0, en_prev=0, dir_prev=0, miss counter=0.
REQ-017 Reset release SHALL take effect on the first rising clki edge after reset_n goes high, with no extra synchronizer stages inside the block.
REQ-018 Reset asserted mid-operation SHALL discard all history; after release, relock follows REQ-007.

Structure
REQ-019 A shared package SHALL hold:
- the FSM state enum (UNLOCKED, LOCKED, FAULT);
- BCD_MAX=9;
- MISS_LIMIT=3;
- CNT_W=8.
REQ-020 The prediction logic SHALL be one combinational sub-module, bcd_next_predict (inputs q_prev, en, dir; output expected), shared with future counter blocks.
REQ-021 The rest SHALL be a single sequential process plus output decode; total 120-400 lines of RTL.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then enable=1, direction=0, q follows 0..9,0,1 -> locked=1 from cycle 2, error never pulses, wrap_count=1.
- direction=1 with q 3,2,1,0,9,8 -> no error, wrap_count increments once at 0->9.
- Locked at q=4 with enable=0 while q jumps to 7 -> error pulse 1 cycle later, err_count=1; next q=7 hold -> no error (resynced).
- Inject q=12 three consecutive cycles -> err_count=3, fault=1, locked=0; further stimulus leaves counters unchanged; clear -> fault=0, counters=0, UNLOCKED.
- Assert reset_n low mid-count at q=6, wrap_count=5 -> all outputs 0 immediately without waiting for a clock edge; relock on the first legal q after release.
- Force 260 isolated mismatches -> err_count saturates at 255 and error still pulses each time.
